// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard scheduler.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Execute-stage operand forwarding select for one ALU source operand.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  output logic [1:0] fwd
);

  // Memory stage holds the younger result, so it wins over writeback.
  always_comb begin
    fwd = FWD_RF;
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      fwd = FWD_MEM;
    end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline stall/flush/forward control with a debug halt/single-step FSM
// and saturating stall/flush event counters.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic             resultsrc_e,
  input  logic             pcsrc_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             clr_cnt,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e           state_q;
  logic [DW-1:0]    drain_q;
  logic             halted_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             lu;
  logic             issuing;
  logic             stall_evt;

  forward_unit u_fwd_a (
    .rs_e       (rs1_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .fwd        (forward_a_e)
  );

  forward_unit u_fwd_b (
    .rs_e       (rs2_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .fwd        (forward_b_e)
  );

  assign lu        = resultsrc_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign issuing   = (state_q == RUN) || (state_q == STEP);
  assign stall_evt = issuing && lu && !pcsrc_e;

  // A taken branch always lets the PC capture its target, even while draining.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (pcsrc_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (!issuing || lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (halt_req) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          if (drain_q == DW'(DRAIN_CYC - 1)) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end else if (step_req) begin
            state_q  <= STEP;
            halted_q <= 1'b0;
          end
        end
        STEP: begin
          state_q <= DRAIN;
          drain_q <= '0;
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (clr_cnt) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (pcsrc_e && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
